// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-road + pedestrian phase scheduler with min/max green, clearance and night flash.
// Latency: requests are latched on the next clk edge; lamps follow the state register with no input path.
// Backpressure: none; level/pulse requests are held in pending flags until their phase is served.
module traffic_phase_scheduler #(
    parameter int T_MIN_GREEN = 4,
    parameter int T_MAX_GREEN = 10,
    parameter int T_YELLOW    = 2,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 3,
    parameter int T_FLASH     = 1,
    parameter int TW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          modo,
    input  logic          req_A,
    input  logic          req_B,
    input  logic          ped_btn,
    output logic          A_green,
    output logic          A_yellow,
    output logic          A_red,
    output logic          B_green,
    output logic          B_yellow,
    output logic          B_red,
    output logic          walk,
    output logic          ped_wait,
    output logic [3:0]    phase
);

    typedef enum logic [3:0] {
        A_GO      = 4'd0,
        A_YEL     = 4'd1,
        CLR_A     = 4'd2,
        B_GO      = 4'd3,
        B_YEL     = 4'd4,
        CLR_B     = 4'd5,
        PED_WALK  = 4'd6,
        FLASH_ON  = 4'd7,
        FLASH_OFF = 4'd8
    } state_t;

    localparam logic [TW-1:0] MIN_G  = TW'(T_MIN_GREEN);
    localparam logic [TW-1:0] MAX_G  = TW'(T_MAX_GREEN);
    localparam logic [TW-1:0] YEL_T  = TW'(T_YELLOW);
    localparam logic [TW-1:0] CLR_T  = TW'(T_ALLRED);
    localparam logic [TW-1:0] WALK_T = TW'(T_WALK);
    localparam logic [TW-1:0] FLSH_T = TW'(T_FLASH);
    localparam logic [TW-1:0] T_SAT  = '1;
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    state_t        state;
    state_t        nxt;
    logic [TW-1:0] t;
    logic          pend_A;
    logic          pend_B;
    logic          pend_ped;
    logic          last_b;     // 0: road A was the last road cleared, 1: road B
    logic          is_flash;
    logic          nxt_flash;

    assign is_flash  = (state == FLASH_ON) || (state == FLASH_OFF);
    assign nxt_flash = (nxt == FLASH_ON) || (nxt == FLASH_OFF);

    always_comb begin
        nxt = state;
        if (modo && !is_flash) begin
            nxt = FLASH_ON;
        end else begin
            case (state)
                A_GO:      if ((pend_B || pend_ped) &&
                               ((t >= MAX_G) || ((t >= MIN_G) && !req_A))) nxt = A_YEL;
                A_YEL:     if (t >= YEL_T) nxt = CLR_A;
                CLR_A:     if (t >= CLR_T) nxt = pend_ped ? PED_WALK : B_GO;
                B_GO:      if ((pend_A || pend_ped) &&
                               ((t >= MAX_G) || ((t >= MIN_G) && !req_B))) nxt = B_YEL;
                B_YEL:     if (t >= YEL_T) nxt = CLR_B;
                CLR_B:     if (t >= CLR_T) nxt = pend_ped ? PED_WALK : A_GO;
                PED_WALK:  if (t >= WALK_T) begin
                               if (!last_b) nxt = pend_B ? B_GO : A_GO;
                               else         nxt = pend_A ? A_GO : B_GO;
                           end
                FLASH_ON:  if (!modo) nxt = CLR_B;
                           else if (t >= FLSH_T) nxt = FLASH_OFF;
                FLASH_OFF: if (!modo) nxt = CLR_B;
                           else if (t >= FLSH_T) nxt = FLASH_ON;
                default:   nxt = A_GO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= A_GO;
            t        <= T_ONE;
            pend_A   <= 1'b0;
            pend_B   <= 1'b0;
            pend_ped <= 1'b0;
            last_b   <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state)   t <= T_ONE;
            else if (t != T_SAT) t <= t + 1'b1;

            if (state == CLR_A && t >= CLR_T) last_b <= 1'b0;
            if (state == CLR_B && t >= CLR_T) last_b <= 1'b1;

            // Entering a phase clears its flag even if the request is still asserted.
            if (is_flash || nxt_flash) begin
                pend_A   <= 1'b0;
                pend_B   <= 1'b0;
                pend_ped <= 1'b0;
            end else begin
                pend_A   <= (nxt == A_GO && state != A_GO) ? 1'b0
                          : (pend_A || (req_A && state != A_GO));
                pend_B   <= (nxt == B_GO && state != B_GO) ? 1'b0
                          : (pend_B || (req_B && state != B_GO));
                pend_ped <= (nxt == PED_WALK && state != PED_WALK) ? 1'b0
                          : (pend_ped || (ped_btn && state != PED_WALK));
            end
        end
    end

    always_comb begin
        A_green  = 1'b0;
        A_yellow = 1'b0;
        A_red    = 1'b0;
        B_green  = 1'b0;
        B_yellow = 1'b0;
        B_red    = 1'b0;
        walk     = 1'b0;
        case (state)
            A_GO:      begin A_green = 1'b1; B_red    = 1'b1; end
            A_YEL:     begin A_yellow = 1'b1; B_red   = 1'b1; end
            B_GO:      begin A_red   = 1'b1; B_green  = 1'b1; end
            B_YEL:     begin A_red   = 1'b1; B_yellow = 1'b1; end
            CLR_A,
            CLR_B:     begin A_red   = 1'b1; B_red    = 1'b1; end
            PED_WALK:  begin A_red   = 1'b1; B_red    = 1'b1; walk = 1'b1; end
            FLASH_ON:  begin A_yellow = 1'b1; B_yellow = 1'b1; end
            default:   ;
        endcase
    end

    assign ped_wait = pend_ped;
    assign phase    = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed vector bench for traffic_phase_scheduler: table of per-cycle inputs/expected lamps plus flash and async-reset sequences.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       modo, req_A, req_B, ped_btn;
    logic       A_green, A_yellow, A_red, B_green, B_yellow, B_red, walk, ped_wait;
    logic [3:0] phase;

    traffic_phase_scheduler dut (
        .clk(clk), .reset(reset), .modo(modo),
        .req_A(req_A), .req_B(req_B), .ped_btn(ped_btn),
        .A_green(A_green), .A_yellow(A_yellow), .A_red(A_red),
        .B_green(B_green), .B_yellow(B_yellow), .B_red(B_red),
        .walk(walk), .ped_wait(ped_wait), .phase(phase)
    );

    always #5 clk = ~clk;

    // Lamp vectors ordered {A_green, A_yellow, A_red, B_green, B_yellow, B_red, walk}
    localparam logic [6:0] L_AGO  = 7'b1000010;
    localparam logic [6:0] L_AYEL = 7'b0100010;
    localparam logic [6:0] L_BGO  = 7'b0011000;
    localparam logic [6:0] L_BYEL = 7'b0010100;
    localparam logic [6:0] L_CLR  = 7'b0010010;
    localparam logic [6:0] L_PED  = 7'b0010011;
    localparam logic [6:0] L_FON  = 7'b0100100;
    localparam logic [6:0] L_FOFF = 7'b0000000;

    typedef struct packed {
        logic       rst;
        logic       modo;
        logic       ra;
        logic       rb;
        logic       pb;
        logic [3:0] ph;
        logic [6:0] lamps;
        logic       pw;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic rst, input logic md, input logic ra, input logic rb,
                                input logic pb, input logic [3:0] ph, input logic [6:0] lamps,
                                input logic pw);
        vec_t v;
        v.rst = rst; v.modo = md; v.ra = ra; v.rb = rb; v.pb = pb;
        v.ph = ph; v.lamps = lamps; v.pw = pw;
        return v;
    endfunction

    task automatic add(input vec_t v, input int n);
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] ph,
                         input logic [6:0] lamps, input logic pw);
        logic [6:0] got_l;
        got_l = {A_green, A_yellow, A_red, B_green, B_yellow, B_red, walk};
        n_tests++;
        if (phase !== ph || got_l !== lamps || ped_wait !== pw) begin
            n_fail++;
            $display("FAIL %s #%0d: got phase=%0d lamps=%b ped_wait=%b, expected phase=%0d lamps=%b ped_wait=%b",
                     name, idx, phase, got_l, ped_wait, ph, lamps, pw);
        end
    endtask

    // Inputs driven 1ns after the edge, outputs sampled 2ns later, then advance one cycle.
    task automatic step(input vec_t v, input string name, input int idx);
        reset   = v.rst;
        modo    = v.modo;
        req_A   = v.ra;
        req_B   = v.rb;
        ped_btn = v.pb;
        #2;
        check(name, idx, v.ph, v.lamps, v.pw);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; modo = 1'b0; req_A = 1'b0; req_B = 1'b0; ped_btn = 1'b0;
        @(posedge clk);
        #1;

        // Idle after reset, long enough for the dwell timer to saturate, then a late req_B.
        add(mk(1,0,0,0,0, 4'd0, L_AGO, 0), 1);
        add(mk(0,0,0,0,0, 4'd0, L_AGO, 0), 20);
        add(mk(0,0,0,1,0, 4'd0, L_AGO, 0), 1);
        add(mk(0,0,0,0,0, 4'd0, L_AGO, 0), 1);
        add(mk(0,0,0,0,0, 4'd1, L_AYEL, 0), 2);
        add(mk(0,0,0,0,0, 4'd2, L_CLR, 0), 1);
        add(mk(0,0,0,0,0, 4'd3, L_BGO, 0), 3);

        // req_B pulse on the first cycle: min green, yellow, all-red, then B rests.
        add(mk(1,0,0,0,0, 4'd0, L_AGO, 0), 1);
        add(mk(0,0,0,1,0, 4'd0, L_AGO, 0), 1);
        add(mk(0,0,0,0,0, 4'd0, L_AGO, 0), 3);
        add(mk(0,0,0,0,0, 4'd1, L_AYEL, 0), 2);
        add(mk(0,0,0,0,0, 4'd2, L_CLR, 0), 1);
        add(mk(0,0,0,0,0, 4'd3, L_BGO, 0), 6);

        // req_A held: max green, then A is served again after B's min green.
        add(mk(1,0,0,0,0, 4'd0, L_AGO, 0), 1);
        add(mk(0,0,1,1,0, 4'd0, L_AGO, 0), 1);
        add(mk(0,0,1,0,0, 4'd0, L_AGO, 0), 9);
        add(mk(0,0,1,0,0, 4'd1, L_AYEL, 0), 2);
        add(mk(0,0,1,0,0, 4'd2, L_CLR, 0), 1);
        add(mk(0,0,1,0,0, 4'd3, L_BGO, 0), 4);
        add(mk(0,0,1,0,0, 4'd4, L_BYEL, 0), 2);
        add(mk(0,0,1,0,0, 4'd5, L_CLR, 0), 1);
        add(mk(0,0,1,0,0, 4'd0, L_AGO, 0), 4);

        // Pedestrian and req_B together: walk phase inserted before B.
        add(mk(1,0,0,0,0, 4'd0, L_AGO, 0), 1);
        add(mk(0,0,0,1,1, 4'd0, L_AGO, 0), 1);
        add(mk(0,0,0,0,0, 4'd0, L_AGO, 1), 3);
        add(mk(0,0,0,0,0, 4'd1, L_AYEL, 1), 2);
        add(mk(0,0,0,0,0, 4'd2, L_CLR, 1), 1);
        add(mk(0,0,0,0,0, 4'd6, L_PED, 0), 3);
        add(mk(0,0,0,0,0, 4'd3, L_BGO, 0), 3);

        for (int i = 0; i < vq.size(); i++) step(vq[i], "table", i);

        // Flash entered from B_YEL, buttons ignored while flashing, exit via CLR_B to A_GO.
        step(mk(1,0,0,0,0, 4'd0, L_AGO, 0), "flash", 0);
        step(mk(0,0,0,1,0, 4'd0, L_AGO, 0), "flash", 1);
        for (int i = 2; i <= 4; i++) step(mk(0,0,0,0,0, 4'd0, L_AGO, 0), "flash", i);
        for (int i = 5; i <= 6; i++) step(mk(0,0,0,0,0, 4'd1, L_AYEL, 0), "flash", i);
        step(mk(0,0,0,0,0, 4'd2, L_CLR, 0), "flash", 7);
        step(mk(0,0,1,0,0, 4'd3, L_BGO, 0), "flash", 8);
        for (int i = 9; i <= 11; i++) step(mk(0,0,0,0,0, 4'd3, L_BGO, 0), "flash", i);
        step(mk(0,1,0,0,0, 4'd4, L_BYEL, 0), "flash", 12);
        step(mk(0,1,0,0,0, 4'd7, L_FON, 0), "flash", 13);
        step(mk(0,1,1,1,1, 4'd8, L_FOFF, 0), "flash", 14);
        step(mk(0,1,0,0,0, 4'd7, L_FON, 0), "flash", 15);
        step(mk(0,1,0,0,0, 4'd8, L_FOFF, 0), "flash", 16);
        step(mk(0,0,0,0,0, 4'd7, L_FON, 0), "flash", 17);
        step(mk(0,0,0,0,0, 4'd5, L_CLR, 0), "flash", 18);
        for (int i = 19; i <= 24; i++) step(mk(0,0,0,0,0, 4'd0, L_AGO, 0), "flash", i);

        // Asynchronous reset in the middle of a walk phase with B pending.
        step(mk(1,0,0,0,0, 4'd0, L_AGO, 0), "mid_reset", 0);
        step(mk(0,0,0,1,1, 4'd0, L_AGO, 0), "mid_reset", 1);
        for (int i = 2; i <= 4; i++) step(mk(0,0,0,0,0, 4'd0, L_AGO, 1), "mid_reset", i);
        for (int i = 5; i <= 6; i++) step(mk(0,0,0,0,0, 4'd1, L_AYEL, 1), "mid_reset", i);
        step(mk(0,0,0,0,0, 4'd2, L_CLR, 1), "mid_reset", 7);
        step(mk(0,0,0,0,0, 4'd6, L_PED, 0), "mid_reset", 8);
        #2;
        check("mid_reset", 9, 4'd6, L_PED, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", 10, 4'd0, L_AGO, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 11; i <= 24; i++) step(mk(0,0,0,0,0, 4'd0, L_AGO, 0), "after_reset", i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-driven scheduler for a two-road intersection (road A, road B) with a shared pedestrian crossing phase.
- Arbitrates green time among three requesters: A vehicle sensor, B vehicle sensor and pedestrian button. Enforces minimum and maximum green, yellow and all-red clearance.
- Supports the night flashing mode (`modo`).
- Drives the six vehicle lamps, the walk lamp and status outputs directly.

Parameters:
- T_MIN_GREEN, 4, minimum green cycles before a green phase may be released
- T_MAX_GREEN, 10, maximum green cycles while the other side waits
- T_YELLOW, 2, yellow duration in cycles
- T_ALLRED, 1, all-red clearance duration in cycles
- T_WALK, 3, pedestrian walk duration in cycles
- T_FLASH, 1, cycles per half-period of flashing yellow
- TW, 4, timer width; must hold max(all T_*); timer saturates at 2^TW-1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- modo  in  1  0 = normal scheduling, 1 = flashing yellow
- req_A  in  1  vehicle present on road A (level)
- req_B  in  1  vehicle present on road B (level)
- ped_btn  in  1  pedestrian button (pulse or level)
- A_green, A_yellow, A_red  out  1 each  road A lamps
- B_green, B_yellow, B_red  out  1 each  road B lamps
- walk  out  1  pedestrian walk lamp
- ped_wait  out  1  pedestrian request pending (pend_ped)
- phase  out  4  current state code, for debug

Behaviour:
- **Interface.** One clock; reset is asynchronous and active-high (`clk`, `reset`). All state changes occur on posedge clk.
- **States** (codes 0..8): A_GO, A_YEL, CLR_A, B_GO, B_YEL, CLR_B, PED_WALK, FLASH_ON, FLASH_OFF.
- **Reset values.** state = A_GO, t = 1, pend_A/pend_B/pend_ped = 0, last_road = A. Outputs therefore show A_green=1, B_red=1 and all others 0.
- **Dwell timer t.** t = 1 in the first cycle of a state. On a state change, t <= 1; otherwise t <= t + 1, saturating at 2^TW-1. A timed state lasting T holds for exactly T cycles (exit when t >= T).
- **Pending flags.**
  - pend_B is set by req_B in any state except B_GO; pend_A is set symmetrically.
  - pend_ped is set by ped_btn in any state except PED_WALK.
  - Each flag clears on the clock edge that enters its serving state. Clear wins over a simultaneous set.
  - All flags are held at 0 while in FLASH_ON/FLASH_OFF.
- **A_GO transition.** Go to A_YEL when (pend_B | pend_ped) and (t >= T_MAX_GREEN, or (t >= T_MIN_GREEN and !req_A)). Otherwise rest in green indefinitely.
- **B_GO transition.** Symmetric to A_GO, using pend_A | pend_ped and req_B.
- **Yellow.** A_YEL goes to CLR_A after T_YELLOW cycles; B_YEL goes to CLR_B likewise.
- **After CLR_A** (T_ALLRED cycles), with last_road <= A:
  - PED_WALK if pend_ped;
  - else B_GO.
- **After CLR_B** (T_ALLRED cycles), with last_road <= B:
  - PED_WALK if pend_ped;
  - else A_GO.
- **PED_WALK** (T_WALK cycles):
  - goes to the road opposite last_road if that road's pend flag is set;
  - else back to the road given by last_road.
- **Flash mode.**
  - modo = 1 in any non-flash state: next state is FLASH_ON, regardless of timer.
  - FLASH_ON and FLASH_OFF alternate every T_FLASH cycles.
  - modo = 0 in either flash state: next state is CLR_B, which then proceeds to A_GO.
- **Lamp decode.** Combinational from the state register only (no input paths to outputs). Exactly one vehicle lamp per road is on, except in the flash states.
  - A_GO: A_green, B_red
  - A_YEL: A_yellow, B_red
  - B_GO: A_red, B_green
  - B_YEL: A_red, B_yellow
  - CLR_A, CLR_B: A_red, B_red
  - PED_WALK: A_red, B_red, walk
  - FLASH_ON: A_yellow, B_yellow
  - FLASH_OFF: all off
- **Status outputs.** ped_wait = pend_ped; phase = state code.
- **Reset mid-operation.** Reset immediately forces the reset values, including clearing pending requests.

Test Plan:
1. Reset, all requests 0, modo = 0 for 20 cycles -> A_green=1 and B_red=1 every cycle; phase=0.
2. One-cycle req_B pulse at cycle 1 with req_A=0 -> A_GO for 4 cycles, A_yellow for 2, all-red for 1, then B_green; pend_B=0 from B_GO entry; rests in B_GO.
3. req_A held 1 with a req_B pulse -> A_green lasts exactly 10 cycles (max green), then yellow 2, all-red 1, B_GO.
4. ped_btn and req_B pulsed together during A_GO -> A_GO 4, A_YEL 2, CLR_A 1, PED_WALK 3 (walk=1, both red, ped_wait drops at entry), then B_GO.
5. modo=1 asserted during B_YEL -> FLASH_ON next cycle, then yellows toggle every cycle; modo=0 -> one cycle CLR_B, then A_GO; ped_btn pressed during flash leaves ped_wait=0.
6. Reset pulsed mid PED_WALK with pend_B=1 -> asynchronously returns to A_GO outputs, walk=0, pend flags cleared; no B service afterwards without a new req_B.
